fp_norm_round32: RTL and testbench

Normalize-and-round stage that consumes the expanded product produced by the single-precision multiplier and packs it into an IEEE-754 binary32 result with exception flags. It sits directly downstream of the multiplier. Its input is sign, an 8-bit biased exponent and a 48-bit significand whose top two bits are whole bits. It is a four-stage pipeline, accepts one operand per enabled clock, and is qualified by the shared `ce`.

---
 rtl/fp_norm_round32_pkg.sv | 78 +++++++
 rtl/fp_norm_round32_cntlz.sv | 16 +
 rtl/fp_norm_round32.sv | 229 ++++++++++++++++++++++
 tb/tb_fp_norm_round32.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_round32_pkg.sv
// Shared FP32 types, constants and pipeline bundles for the
// normalize-and-round stage (optional subnormal support: FP_DENORM_EN).
package fp32Pkg;

  localparam int EX   = 56;
  localparam int SW   = 48;
  localparam int FX   = 23;
  localparam int FMSB = FX - 1;
  localparam int EMSB = 30;

  typedef struct packed {
    logic            sign;
    logic [7:0]      exp;
    logic [FMSB:0]   frac;
  } FP32;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fp_rm_t;

  typedef enum logic [2:0] {
    CL_NORM  = 3'd0,
    CL_SUB   = 3'd1,
    CL_SPEC  = 3'd2,
    CL_ZERO  = 3'd3,
    CL_FLUSH = 3'd4
  } fp_cls_t;

  localparam logic [30:0] FP32_MAXFIN = 31'h7F7FFFFF;
  localparam logic [30:0] FP32_INF    = 31'h7F800000;

  typedef struct packed {
    logic          v;
    logic          sign;
    logic [SW-1:0] sig;
    logic [5:0]    lz;
    logic [9:0]    e;
    logic          spec;
    logic          zero;
    logic          under;
    fp_rm_t        rm;
  } s1_t;

  typedef struct packed {
    logic       v;
    logic       sign;
    fp_cls_t    cls;
    fp_rm_t     rm;
    logic [9:0] e;
    logic [23:0] man;
    logic       g;
    logic       s;
  } s2_t;

  typedef struct packed {
    logic       v;
    logic       sign;
    fp_cls_t    cls;
    fp_rm_t     rm;
    logic [9:0] e;
    logic [24:0] man;
    logic       nx;
  } s3_t;

  function automatic fp_rm_t rm_fix(
    input logic [2:0] r,
    input logic [2:0] dflt
  );
    fp_rm_t m;
    m = (r > 3'd4) ? fp_rm_t'(dflt) : fp_rm_t'(r);
    return m;
  endfunction

endpackage

// File: rtl/fp_norm_round32_cntlz.sv
// 48-bit leading-zero counter; all-zero input
// yields 48.
module fp_cntlz48 (
  input  logic [47:0] sig_i,
  output logic [5:0]  cnt_o
);

  // highest set bit wins, so scan upward
  always_comb begin
    cnt_o = 6'd48;
    for (int k = 0; k < 48; k++) begin
      if (sig_i[k]) cnt_o = 6'(47 - k);
    end
  end

endmodule

// File: rtl/fp_norm_round32.sv
// Four-stage normalize/round/pack of the expanded FP32 product.
// Macro FP_DENORM_EN enables gradual underflow instead of flush.
module fp_norm_round32
  import fp32Pkg::*;
#(
  parameter logic [2:0] RM_DEFAULT = 3'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          i_valid,
  input  logic [EX:0]   i,
  input  logic          i_under,
  input  logic [2:0]    rm,
  output logic          o_valid,
  output logic [31:0]   o,
  output logic          inexact,
  output logic          overflow,
  output logic          underflow
);

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic [5:0]  lz;
  logic [7:0]  in_exp;
  logic [47:0] in_sig;

  assign in_exp = i[EX-1:EX-8];
  assign in_sig = i[SW-1:0];

  fp_cntlz48 u_lz (
    .sig_i (in_sig),
    .cnt_o (lz)
  );

  // stage 1: classify input, count zeros, form working exponent
  always_comb begin
    s1_d       = '0;
    s1_d.v     = i_valid;
    s1_d.sign  = i[EX];
    s1_d.sig   = in_sig;
    s1_d.lz    = lz;
    s1_d.e     = {2'b00, in_exp} + 10'd1 - {4'b0000, lz};
    s1_d.spec  = (in_exp == 8'hFF);
    s1_d.zero  = (in_sig == '0);
    s1_d.under = i_under;
    s1_d.rm    = rm_fix(rm, RM_DEFAULT);
  end

  logic [47:0] norm;
  logic        tiny;
`ifdef FP_DENORM_EN
  logic [9:0]  rsh;
  logic [4:0]  sh;
  logic [47:0] mask;
  logic [47:0] den;
  logic        lost;
`endif

  // stage 2: normalize and pick the result class
  always_comb begin
    norm = s1_q.sig << s1_q.lz;
    tiny = s1_q.e[9] || (s1_q.e == '0);
`ifdef FP_DENORM_EN
    rsh  = 10'd1 - s1_q.e;
    sh   = (rsh > 10'd26) ? 5'd26 : rsh[4:0];
    mask = (48'd1 << sh) - 48'd1;
    den  = norm >> sh;
    lost = |(norm & mask);
`endif
    s2_d      = '0;
    s2_d.v    = s1_q.v;
    s2_d.sign = s1_q.sign;
    s2_d.rm   = s1_q.rm;
    s2_d.e    = s1_q.e;
    s2_d.cls  = CL_NORM;
    s2_d.man  = norm[47:24];
    s2_d.g    = norm[23];
    s2_d.s    = |norm[22:0];
    if (s1_q.spec) begin
      s2_d.cls = CL_SPEC;
      s2_d.man = {1'b0, s1_q.sig[46:24]};
      s2_d.g   = 1'b0;
      s2_d.s   = 1'b0;
    end else if (s1_q.zero) begin
      s2_d.cls = CL_ZERO;
    end else if (s1_q.under) begin
      s2_d.cls = CL_FLUSH;
    end else if (tiny) begin
`ifdef FP_DENORM_EN
      s2_d.cls = CL_SUB;
      s2_d.man = den[47:24];
      s2_d.g   = den[23];
      s2_d.s   = (|den[22:0]) | lost;
`else
      s2_d.cls = CL_FLUSH;
`endif
    end
  end

  logic inc;
  logic gs;
  logic rnd;

  // stage 3: rounding increment by mode
  always_comb begin
    gs  = s2_q.g | s2_q.s;
    rnd = (s2_q.cls == CL_NORM) ||
          (s2_q.cls == CL_SUB);
    unique case (s2_q.rm)
      RM_RNE:  inc = s2_q.g & (s2_q.s | s2_q.man[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = gs & s2_q.sign;
      RM_RUP:  inc = gs & ~s2_q.sign;
      RM_RMM:  inc = s2_q.g;
      default: inc = 1'b0;
    endcase
    s3_d      = '0;
    s3_d.v    = s2_q.v;
    s3_d.sign = s2_q.sign;
    s3_d.cls  = s2_q.cls;
    s3_d.rm   = s2_q.rm;
    s3_d.e    = s2_q.e;
    s3_d.man  = {1'b0, s2_q.man} +
                {24'd0, rnd & inc};
    s3_d.nx   = rnd ? gs :
                (s2_q.cls == CL_FLUSH);
  end

  FP32        res_d, res_q;
  logic       nx_d, of_d, uf_d;
  logic       nx_q, of_q, uf_q;
  logic       v_q;
  logic [9:0] e2;
  logic       ovf;
  logic       away;

  // stage 4: post-round exponent fix-up, overflow and pack
  always_comb begin
    e2   = s3_q.e + {9'd0, s3_q.man[24]};
    ovf  = !e2[9] && (e2 >= 10'd255);
    away = (s3_q.rm == RM_RNE) ||
           (s3_q.rm == RM_RMM) ||
           ((s3_q.rm == RM_RUP) && !s3_q.sign) ||
           ((s3_q.rm == RM_RDN) && s3_q.sign);
    res_d = '0;
    nx_d  = 1'b0;
    of_d  = 1'b0;
    uf_d  = 1'b0;
    unique case (1'b1)
      (s3_q.cls == CL_SPEC): begin
        res_d = {s3_q.sign, 8'hFF,
                 s3_q.man[22:0]};
      end
      (s3_q.cls == CL_ZERO): begin
        res_d = {s3_q.sign, 31'd0};
      end
      (s3_q.cls == CL_FLUSH): begin
        res_d = {s3_q.sign, 31'd0};
        nx_d  = 1'b1;
        uf_d  = 1'b1;
      end
      (s3_q.cls == CL_SUB): begin
        res_d = {s3_q.sign, 7'd0,
                 s3_q.man[23],
                 s3_q.man[22:0]};
        nx_d  = s3_q.nx;
        uf_d  = ~s3_q.man[23] & s3_q.nx;
      end
      (s3_q.cls == CL_NORM): begin
        if (ovf) begin
          res_d = away ?
                  {s3_q.sign, FP32_INF} :
                  {s3_q.sign, FP32_MAXFIN};
          nx_d  = 1'b1;
          of_d  = 1'b1;
        end else begin
          res_d = {s3_q.sign, e2[7:0],
                   s3_q.man[22:0]};
          nx_d  = s3_q.nx;
        end
      end
      default: begin
        res_d = '0;
      end
    endcase
  end

  // pipeline registers advance only on enabled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (ce) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // output register; data holds while no result emerges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      res_q <= '0;
      nx_q  <= 1'b0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else if (ce) begin
      v_q <= s3_q.v;
      if (s3_q.v) begin
        res_q <= res_d;
        nx_q  <= nx_d;
        of_q  <= of_d;
        uf_q  <= uf_d;
      end
    end
  end

  assign o_valid   = v_q;
  assign o         = res_q;
  assign inexact   = nx_q;
  assign overflow  = of_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_fp_norm_round32.sv
// Directed bench for fp_norm_round32 with a result
// scoreboard, random ce stalls and mid-flight reset.
module tb_fp_norm_round32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic        i_valid = 1'b0;
  logic [56:0] i = '0;
  logic        i_under = 1'b0;
  logic [2:0]  rm = '0;
  logic        o_valid;
  logic [31:0] o;
  logic        inexact, overflow, underflow;

  fp_norm_round32 #(.RM_DEFAULT(3'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .i_valid   (i_valid),
    .i         (i),
    .i_under   (i_under),
    .rm        (rm),
    .o_valid   (o_valid),
    .o         (o),
    .inexact   (inexact),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [34:0] exp_q[$];
  int unsigned due_q[$];
  int unsigned en_cnt = 0;
  bit          ce_q = 1'b0;
  int          vpulse = 0;
  logic [34:0] ev;
  int unsigned dv;

  logic [56:0] tv_i [15];
  logic        tv_u [15];
  logic [2:0]  tv_rm[15];
  logic [34:0] tv_x [15];

  // count enabled edges; remember whether the last edge was enabled
  always @(posedge clk) begin
    ce_q = ce;
    if (ce) en_cnt++;
  end

  // scoreboard: one compare per freshly produced result
  always @(negedge clk) begin
    if (rst_n && ce_q && o_valid) begin
      vpulse++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL extra_out obs=%h exp=none", o);
      end
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        dv = due_q.pop_front();
        checks++;
        assert ({o, inexact, overflow, underflow} === ev)
        else begin
          failures++;
          $error("FAIL result obs=%h_%b%b%b exp=%h_%b",
                 o, inexact, overflow, underflow,
                 ev[34:3], ev[2:0]);
        end
        checks++;
        assert (en_cnt === dv) else begin
          failures++;
          $error("FAIL latency obs=%0d exp=%0d", en_cnt, dv);
        end
      end
    end
  end

  task automatic send(input int k, input bit rce);
    int tries;
    tries = 0;
    i = tv_i[k];
    i_under = tv_u[k];
    rm = tv_rm[k];
    i_valid = 1'b1;
    ce = rce ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!ce) begin
      @(negedge clk);
      tries++;
      ce = (rce && tries < 6) ?
           1'($urandom_range(0, 1)) : 1'b1;
    end
    exp_q.push_back(tv_x[k]);
    due_q.push_back(en_cnt + 4);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit rce);
    i_valid = 1'b0;
    repeat (n) begin
      ce = rce ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    tv_i[0]  = {1'b0, 8'h7F, 48'h600000000000};
    tv_u[0]  = 0; tv_rm[0] = 3'd0;
    tv_x[0]  = {32'h3FC00000, 3'b000};
    tv_i[1]  = {1'b0, 8'h7F, 48'h400000400000};
    tv_u[1]  = 0; tv_rm[1] = 3'd0;
    tv_x[1]  = {32'h3F800000, 3'b100};
    tv_i[2]  = tv_i[1];
    tv_u[2]  = 0; tv_rm[2] = 3'd3;
    tv_x[2]  = {32'h3F800001, 3'b100};
    tv_i[3]  = {1'b0, 8'hFE, 48'h800000000000};
    tv_u[3]  = 0; tv_rm[3] = 3'd0;
    tv_x[3]  = {32'h7F800000, 3'b110};
    tv_i[4]  = tv_i[3];
    tv_u[4]  = 0; tv_rm[4] = 3'd1;
    tv_x[4]  = {32'h7F7FFFFF, 3'b110};
    tv_i[5]  = {1'b0, 8'hFF, 48'hC00000000000};
    tv_u[5]  = 0; tv_rm[5] = 3'd0;
    tv_x[5]  = {32'h7FC00000, 3'b000};
    tv_i[6]  = {1'b0, 8'hFF, 48'h0};
    tv_u[6]  = 0; tv_rm[6] = 3'd0;
    tv_x[6]  = {32'h7F800000, 3'b000};
    tv_i[7]  = {1'b0, 8'h00, 48'h400000000000};
    tv_u[7]  = 0; tv_rm[7] = 3'd0;
`ifdef FP_DENORM_EN
    tv_x[7]  = {32'h00400000, 3'b000};
`else
    tv_x[7]  = {32'h00000000, 3'b101};
`endif
    tv_i[8]  = {1'b1, 8'h7F, 48'h400000400000};
    tv_u[8]  = 0; tv_rm[8] = 3'd2;
    tv_x[8]  = {32'hBF800001, 3'b100};
    tv_i[9]  = tv_i[1];
    tv_u[9]  = 0; tv_rm[9] = 3'd4;
    tv_x[9]  = {32'h3F800001, 3'b100};
    tv_i[10] = {1'b0, 8'h7F, 48'h7FFFFFFFFFFF};
    tv_u[10] = 0; tv_rm[10] = 3'd1;
    tv_x[10] = {32'h3FFFFFFF, 3'b100};
    tv_i[11] = tv_i[10];
    tv_u[11] = 0; tv_rm[11] = 3'd7;
    tv_x[11] = {32'h40000000, 3'b100};
    tv_i[12] = {1'b1, 8'h50, 48'h0};
    tv_u[12] = 0; tv_rm[12] = 3'd0;
    tv_x[12] = {32'h80000000, 3'b000};
    tv_i[13] = {1'b0, 8'h7F, 48'h400000000000};
    tv_u[13] = 1; tv_rm[13] = 3'd0;
    tv_x[13] = {32'h00000000, 3'b101};
    tv_i[14] = {1'b1, 8'hFE, 48'h800000000000};
    tv_u[14] = 0; tv_rm[14] = 3'd2;
    tv_x[14] = {32'hFF800000, 3'b110};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    assert (o_valid === 1'b0) else begin
      failures++;
      $error("FAIL rst_valid obs=%b exp=0", o_valid);
    end
    checks++;
    assert (o === 32'h0) else begin
      failures++;
      $error("FAIL rst_o obs=%h exp=0", o);
    end
    checks++;
    assert ({inexact, overflow, underflow} === 3'b000)
    else begin
      failures++;
      $error("FAIL rst_flags obs=%b%b%b exp=000",
             inexact, overflow, underflow);
    end
    rst_n = 1'b1;
    idle(2, 1'b0);

    for (int k = 0; k < 15; k++) send(k, 1'b0);
    idle(8, 1'b0);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain_dir obs=%0d exp=0", exp_q.size());
    end

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 15; k++) begin
        send(k, 1'b1);
        if (k % 4 == 3) idle(2, 1'b1);
      end
    end
    idle(10, 1'b0);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain_rnd obs=%0d exp=0", exp_q.size());
    end

    send(0, 1'b0);
    send(3, 1'b0);
    send(13, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    base = vpulse;
    idle(2, 1'b0);
    checks++;
    assert (o_valid === 1'b0) else begin
      failures++;
      $error("FAIL midrst_valid obs=%b exp=0", o_valid);
    end
    rst_n = 1'b1;
    idle(10, 1'b0);
    checks++;
    assert (vpulse == base) else begin
      failures++;
      $error("FAIL ghost_out obs=%0d exp=%0d", vpulse, base);
    end

    send(1, 1'b0);
    idle(8, 1'b0);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain_post obs=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
